// File: rtl/dma_snd_shifter.sv
// rtl/dma_snd_shifter.sv - DMA sound FIFO and sample shifter; optional status flags via DMA_SND_STATUS_EN
module dma_snd_shifter (
   input  logic        clk32,
   input  logic        res,
   input  logic        play,
   input  logic        mono,
   input  logic [1:0]  srate,
   input  logic        sload_n,
   input  logic [15:0] din,
   output logic        sreq,
   output logic [7:0]  left,
   output logic [7:0]  right,
   output logic        sstb,
   output logic        ovf,
   output logic        udr
);

   logic [15:0] fifo_mem [4];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic [2:0]  level;
   logic [2:0]  level_next;
   logic [12:0] count;
   logic [12:0] terminal;
   logic        sload_prev;
   logic        byte_ptr;
   logic        tick;
   logic        have_data;
   logic        write_req;
   logic        write_ok;
   logic        pop;
   logic [15:0] head;
   logic [7:0]  mono_byte;

   assign head      = fifo_mem[rd_ptr];
   assign mono_byte = byte_ptr ? head[7:0] : head[15:8];

   // Terminal count per sample rate, plus tick/write/pop decisions for this cycle
   always_comb begin
      terminal = 13'd5119;
      case (srate)
         2'd0: terminal = 13'd5119;
         2'd1: terminal = 13'd2559;
         2'd2: terminal = 13'd1279;
         2'd3: terminal = 13'd639;
         default: terminal = 13'd5119;
      endcase
      // >= rather than == so a lowered terminal mid-count fires at once instead of wrapping
      tick       = play && (count >= terminal);
      have_data  = (level != 3'd0);
      write_req  = play && !sload_n && sload_prev;
      // Mono only releases the word once its low byte has been played
      pop        = tick && have_data && (!mono || byte_ptr);
      // A full FIFO still takes a write when the head leaves on the same cycle
      write_ok   = write_req && ((level != 3'd4) || pop);
      level_next = play ? (level + {2'b00, write_ok} - {2'b00, pop}) : 3'd0;
   end

   // Sample-rate prescaler, parked at zero while stopped
   always_ff @(posedge clk32) begin
      if (res || !play || tick) begin
         count <= 13'd0;
      end else begin
         count <= count + 13'd1;
      end
   end

   // Edge detector on the word strobe so a long low pulse writes only once
   always_ff @(posedge clk32) begin
      if (res) begin
         sload_prev <= 1'b1;
      end else begin
         sload_prev <= sload_n;
      end
   end

   // FIFO storage; contents need no reset because level gates every read
   always_ff @(posedge clk32) begin
      if (write_ok) begin
         fifo_mem[wr_ptr] <= din;
      end
   end

   // FIFO pointers, fill level and mono byte pointer
   always_ff @(posedge clk32) begin
      if (res || !play) begin
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         level    <= 3'd0;
         byte_ptr <= 1'b0;
      end else begin
         level <= level_next;
         if (write_ok) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         if (tick && have_data && mono) begin
            byte_ptr <= ~byte_ptr;
         end
      end
   end

   // Sample output register, updated the cycle after a tick that found data
   always_ff @(posedge clk32) begin
      if (res) begin
         left  <= 8'd0;
         right <= 8'd0;
         sstb  <= 1'b0;
      end else begin
         sstb <= 1'b0;
         if (tick && have_data) begin
            sstb <= 1'b1;
            if (mono) begin
               left  <= mono_byte;
               right <= mono_byte;
            end else begin
               left  <= head[15:8];
               right <= head[7:0];
            end
         end
      end
   end

   // Request more words while at most two are buffered after this cycle
   always_ff @(posedge clk32) begin
      if (res) begin
         sreq <= 1'b0;
      end else begin
         sreq <= play && (level_next <= 3'd2);
      end
   end

`ifdef DMA_SND_STATUS_EN
   // Sticky overflow/underrun flags, cleared only by reset
   always_ff @(posedge clk32) begin
      if (res) begin
         ovf <= 1'b0;
         udr <= 1'b0;
      end else begin
         if (write_req && !write_ok) begin
            ovf <= 1'b1;
         end
         if (tick && !have_data) begin
            udr <= 1'b1;
         end
      end
   end
`else
   assign ovf = 1'b0;
   assign udr = 1'b0;
`endif

endmodule

// File: tb/tb_dma_snd_shifter.sv
// tb/tb_dma_snd_shifter.sv - scoreboard bench for dma_snd_shifter with a queue-based reference model
module tb_dma_snd_shifter;

   logic        clk32 = 1'b0;
   logic        res = 1'b1;
   logic        play = 1'b0;
   logic        mono = 1'b0;
   logic [1:0]  srate = 2'd0;
   logic        sload_n = 1'b1;
   logic [15:0] din = 16'd0;
   logic        sreq;
   logic [7:0]  left;
   logic [7:0]  right;
   logic        sstb;
   logic        ovf;
   logic        udr;

   int checks = 0;
   int errors = 0;

`ifdef DMA_SND_STATUS_EN
   bit flags_en = 1'b1;
`else
   bit flags_en = 1'b0;
`endif

   // reference model state
   logic [15:0] m_q[$];
   logic [15:0] exp_q[$];
   int          m_cnt = 0;
   bit          m_bptr = 1'b0;
   bit          m_prev = 1'b1;
   bit          m_ovf = 1'b0;
   bit          m_udr = 1'b0;
   bit          m_sreq = 1'b0;
   bit          m_live = 1'b0;
   logic [7:0]  m_l = 8'd0;
   logic [7:0]  m_r = 8'd0;

   dma_snd_shifter dut (
      .clk32(clk32), .res(res), .play(play), .mono(mono), .srate(srate),
      .sload_n(sload_n), .din(din), .sreq(sreq), .left(left), .right(right),
      .sstb(sstb), .ovf(ovf), .udr(udr)
   );

   always #5 clk32 = ~clk32;

   // one sample period is 5120 cycles at 6.25 kHz, halved per srate step
   function automatic int term_of(input logic [1:0] s);
      return (5120 >> s) - 1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model, evaluated on every rising edge
   initial begin
      bit          wr, tk, popped;
      int          n0;
      logic [15:0] w;
      logic [7:0]  b;
      forever begin
         @(posedge clk32);
         m_live = 1'b1;
         if (res) begin
            m_q.delete();
            exp_q.delete();
            m_cnt = 0; m_bptr = 0; m_prev = 1; m_ovf = 0; m_udr = 0; m_sreq = 0;
            m_l = 8'd0; m_r = 8'd0;
         end else if (!play) begin
            m_q.delete();
            m_cnt = 0; m_bptr = 0; m_sreq = 0;
            m_prev = sload_n;
         end else begin
            wr = !sload_n && m_prev;
            tk = (m_cnt >= term_of(srate));
            n0 = m_q.size();
            popped = 0;
            if (tk) begin
               if (n0 == 0) begin
                  m_udr = 1;
               end else begin
                  w = m_q[0];
                  if (!mono) begin
                     m_l = w[15:8]; m_r = w[7:0];
                     popped = 1;
                  end else begin
                     b = m_bptr ? w[7:0] : w[15:8];
                     m_l = b; m_r = b;
                     if (m_bptr) popped = 1;
                     m_bptr = !m_bptr;
                  end
                  exp_q.push_back({m_l, m_r});
                  if (popped) void'(m_q.pop_front());
               end
            end
            if (wr) begin
               if (n0 < 4 || popped) m_q.push_back(din);
               else m_ovf = 1;
            end
            m_cnt = tk ? 0 : m_cnt + 1;
            m_prev = sload_n;
            m_sreq = (m_q.size() <= 2);
         end
      end
   end

   // monitor: pops the scoreboard whenever the DUT strobes a sample
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk32);
         if (m_live) begin
            chk("sreq", sreq, m_sreq);
            chk("ovf", ovf, flags_en ? m_ovf : 1'b0);
            chk("udr", udr, flags_en ? m_udr : 1'b0);
            if (sstb) begin
               if (exp_q.size() == 0) begin
                  chk("sstb_spurious", sstb, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  chk("left", left, e[15:8]);
                  chk("right", right, e[7:0]);
               end
            end else begin
               if (exp_q.size() != 0) begin
                  chk("sstb_missing", sstb, 1'b1);
                  exp_q.delete();
               end
               chk("left_hold", left, m_l);
               chk("right_hold", right, m_r);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk32);
   endtask

   task automatic pulse(input logic [15:0] d, input int lo, input int gap);
      din = d;
      sload_n = 1'b0;
      cyc(lo);
      sload_n = 1'b1;
      din = 16'($urandom);
      cyc(gap);
   endtask

   task automatic do_reset();
      res = 1'b1;
      cyc(2);
      res = 1'b0;
   endtask

   // stimulus
   initial begin
      int guard;
      int t;
      int r;
      int wp;
      @(negedge clk32);
      cyc(2);
      // reset with play=1, no writes: sreq rises, first tick underruns
      play = 1'b1; srate = 2'd3;
      do_reset();
      cyc(700);
      // stereo directed words
      do_reset();
      pulse(16'h7F80, 1, 2);
      pulse(16'h0102, 2, 2);
      cyc(1400);
      // mono at the slowest rate
      mono = 1'b1; srate = 2'd0;
      do_reset();
      pulse(16'h1234, 1, 3);
      cyc(10300);
      mono = 1'b0; srate = 2'd3;
      // five writes without a tick: fifth overflows
      do_reset();
      for (int i = 0; i < 5; i++) pulse(16'($urandom), 1, 1);
      cyc(5);
      // full FIFO written on the exact tick cycle
      do_reset();
      for (int i = 0; i < 4; i++) pulse(16'($urandom), 1, 1);
      guard = 0;
      while (m_cnt != term_of(srate) && guard < 2000) begin
         cyc(1);
         guard++;
      end
      chk("tick_wait_timeout", (guard < 2000), 1'b1);
      pulse(16'hA55A, 1, 2);
      cyc(10);
      // stop with three words buffered: flush, ignore strobes, hold outputs
      do_reset();
      for (int i = 0; i < 4; i++) pulse(16'($urandom), 1, 1);
      cyc(650);
      play = 1'b0;
      cyc(2);
      pulse(16'hBEEF, 1, 2);
      pulse(16'hCAFE, 3, 2);
      cyc(10);
      play = 1'b1;
      cyc(5);
      // randomized sessions
      for (int s = 0; s < 30; s++) begin
         if ($urandom_range(0, 3) == 0) do_reset();
         play = 1'b1;
         mono = 1'($urandom);
         srate = 2'($urandom_range(2, 3));
         wp = $urandom_range(1, 10);
         t = 0;
         while (t < 1200) begin
            r = $urandom_range(0, 99);
            if (r < wp) begin
               int lo, gap;
               lo = $urandom_range(1, 3);
               gap = $urandom_range(1, 3);
               pulse(16'($urandom), lo, gap);
               t += lo + gap;
            end else if (r == 96) begin
               srate = 2'($urandom_range(2, 3));
               cyc(1); t++;
            end else if (r == 97) begin
               mono = ~mono;
               cyc(1); t++;
            end else if (r == 98) begin
               play = 1'b0;
               cyc(3);
               play = 1'b1;
               t += 3;
            end else begin
               cyc(1); t++;
            end
         end
      end
      play = 1'b0;
      cyc(5);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
